// File: rtl/odo_sbox_small_seq_if.sv
// Handshake/bus bundle for odo_sbox_small_seq.
// Slave side is the sequencer. Master side is the round-state logic, the
// downstream consumer and the S-box ROM seen as one environment.
interface odo_sbox_small_seq_if #(
  parameter int NUM_SYMS = 10
) ();
  localparam int W = 6 * NUM_SYMS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [5:0]   sbox_in;
  logic [5:0]   sbox_out;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    output in_valid, in_data, sbox_out, out_ready,
    input  in_ready, sbox_in, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, sbox_out, out_ready,
    output in_ready, sbox_in, out_valid, out_data
  );
endinterface

// File: rtl/odo_sbox_small_seq.sv
// odo_sbox_small_seq: iterative feeder/collector for one shared 6-bit S-box.
// Accepts a word of NUM_SYMS 6-bit symbols, streams one symbol per cycle to
// the external S-box (read latency SBOX_LAT), drops each registered result
// back into its slot and offers the substituted word downstream.
// Optional: define ODO_SBOX_SEQ_PERF_EN to add the 16-bit saturating
// words_done output-handshake counter.
module odo_sbox_small_seq #(
  parameter int NUM_SYMS = 10,
  parameter int SBOX_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ODO_SBOX_SEQ_PERF_EN
  output logic [15:0] words_done,
`endif
  odo_sbox_small_seq_if.slave bus
);
  localparam int            IW   = (NUM_SYMS > 1) ? $clog2(NUM_SYMS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_SYMS - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t                   state, state_nxt;
  logic [NUM_SYMS-1:0][5:0] src;       // latched input word
  logic [NUM_SYMS-1:0][5:0] res;       // substituted word being assembled
  logic [IW-1:0]            idx;       // symbol currently on sbox_in
  logic [IW-1:0]            idx_inc;
  logic                     accept, emit, last_cap;

  // Capture pipeline: stage k holds the slot of the symbol sent k cycles ago.
  // Stage SBOX_LAT lines up with the S-box result on sbox_out.
  logic [SBOX_LAT:1]          vld_pipe;
  logic [SBOX_LAT:1][IW-1:0]  idx_pipe;

  assign accept   = bus.in_valid && bus.in_ready;
  assign emit     = bus.out_valid && bus.out_ready;
  assign idx_inc  = idx + IW'(1);
  assign last_cap = vld_pipe[SBOX_LAT] && (idx_pipe[SBOX_LAT] == LAST);

  // in_ready and out_valid are decoded from state, so they never overlap.
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = res;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: FEED runs exactly NUM_SYMS cycles, DRAIN waits for the last slot.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = FEED;
      FEED:    if (idx == LAST)   state_nxt = DRAIN;
      DRAIN:   if (last_cap)      state_nxt = DONE;
      DONE:    if (emit)          state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Feeder: symbol 0 goes out on the accept edge itself, so symbol i is on
  // sbox_in during the i-th cycle after accept. sbox_in is 0 outside FEED.
  always_ff @(posedge clk) begin
    if (rst) begin
      src         <= '0;
      idx         <= '0;
      bus.sbox_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.sbox_in <= '0;
          if (accept) begin
            src         <= bus.in_data;
            idx         <= '0;
            bus.sbox_in <= bus.in_data[5:0];
          end
        end
        FEED: begin
          if (idx == LAST) begin
            idx         <= '0;
            bus.sbox_in <= '0;
          end else begin
            idx         <= idx_inc;
            bus.sbox_in <= src[idx_inc];
          end
        end
        default: bus.sbox_in <= '0;
      endcase
    end
  end

  // Capture pipeline shift; cleared on reset so in-flight results are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[1] <= (state == FEED);
      idx_pipe[1] <= idx;
      for (int k = 2; k <= SBOX_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        idx_pipe[k] <= idx_pipe[k-1];
      end
    end
  end

  // Result assembly: sbox_out is only looked at when the last stage is valid.
  always_ff @(posedge clk) begin
    if (rst)                     res <= '0;
    else if (vld_pipe[SBOX_LAT]) res[idx_pipe[SBOX_LAT]] <= bus.sbox_out;
  end

`ifdef ODO_SBOX_SEQ_PERF_EN
  // Output-handshake counter, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst)                               words_done <= '0;
    else if (emit && words_done != 16'hFFFF) words_done <= words_done + 16'd1;
  end
`endif

endmodule

// File: tb/tb_odo_sbox_small_seq.sv
// Self-checking bench for odo_sbox_small_seq (NUM_SYMS=10, SBOX_LAT=1).
// A registered table lookup stands in for odo_sbox_small28; it reproduces
// the entries the directed cases rely on and fills the rest arbitrarily.
module tb_odo_sbox_small_seq;
  localparam int N = 10;
  localparam int L = 1;
  localparam int W = 6 * N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  odo_sbox_small_seq_if #(.NUM_SYMS(N)) bus ();

`ifdef ODO_SBOX_SEQ_PERF_EN
  logic [15:0] words_done;
`endif

  odo_sbox_small_seq #(.NUM_SYMS(N), .SBOX_LAT(L)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef ODO_SBOX_SEQ_PERF_EN
    .words_done (words_done),
`endif
    .bus        (bus)
  );

  function automatic logic [5:0] sbox_f(input logic [5:0] x);
    logic [5:0] y;
    case (x)
      6'h00: y = 6'h29;  6'h01: y = 6'h18;  6'h02: y = 6'h17;
      6'h03: y = 6'h0c;  6'h04: y = 6'h39;  6'h05: y = 6'h04;
      6'h06: y = 6'h0a;  6'h07: y = 6'h25;  6'h08: y = 6'h0e;
      6'h09: y = 6'h01;  6'h3f: y = 6'h33;
      default: begin y = x * 6'd37; y = y ^ 6'h15; end
    endcase
    return y;
  endfunction

  // S-box ROM with one cycle of read latency.
  always @(posedge clk) bus.sbox_out <= sbox_f(bus.sbox_in);

  // Reference: the substituted word is the S-box applied to every symbol.
  function automatic logic [W-1:0] ref_word(input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) r[6*k +: 6] = sbox_f(d[6*k +: 6]);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) r[6*k +: 6] = 6'($urandom_range(0, 63));
    return r;
  endfunction

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_q[$];
  int hs_q[$];
  logic [W-1:0] got_q[$];
  int hs_base = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Log the handshakes that the coming edge will complete, then advance.
  task automatic step();
    if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
    if (bus.out_valid && bus.out_ready) begin
      hs_q.push_back(cyc + 1);
      got_q.push_back(bus.out_data);
    end
    @(negedge clk);
  endtask

  // Offer a word and return at the negedge just after its accept edge.
  task automatic send(input logic [W-1:0] d);
    int t;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 300) begin step(); t++; end
    chk("accept_timeout", 64'(t < 300), 64'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    int t;
    t = 0;
    while (!bus.out_valid && t < 300) begin step(); t++; end
    chk("out_valid_timeout", 64'(t < 300), 64'd1);
    lat = cyc - acc_q[$];
  endtask

  task automatic recv(input string tag, input logic [W-1:0] exp);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk(tag, got_q[$], exp);
    chk({tag, "_ovalid_clr"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    logic [W-1:0] d, d2, expw;
    logic [W-1:0] w [3];
    int lat, k, t, n0;
    logic [5:0] cnt_exp [N];

    cnt_exp = '{6'h29, 6'h18, 6'h17, 6'h0c, 6'h39, 6'h04, 6'h0a, 6'h25, 6'h0e, 6'h01};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    step();
    step();
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_sbox_in", bus.sbox_in, '0);
    rst = 1'b0;
    step();
    chk("idle_in_ready", bus.in_ready, 1'b1);

    // All-zero word.
    send('0);
    wait_out(lat);
    chk("zero_latency", lat, 11);
    chk("zero_data", bus.out_data, 60'hA69A69A69A69A69);
    recv("zero_hs", 60'hA69A69A69A69A69);

    // Symbol k = k; sbox_in must walk 0..9 on consecutive cycles.
    for (int i = 0; i < N; i++) d[6*i +: 6] = 6'(i);
    expw = '0;
    for (int i = 0; i < N; i++) expw[6*i +: 6] = cnt_exp[i];
    send(d);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("seq_sbox_in_%0d", i), bus.sbox_in, 64'(i));
      chk("seq_in_ready_busy", bus.in_ready, 1'b0);
      step();
    end
    chk("seq_sbox_in_drain", bus.sbox_in, '0);
    wait_out(lat);
    chk("seq_latency", lat, 11);
    chk("seq_data", bus.out_data, expw);
    recv("seq_hs", expw);

    // Backpressure with a second word already waiting.
    d  = rand_word();
    d2 = rand_word();
    send(d);
    wait_out(lat);
    bus.in_data  = d2;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("bp_data_hold", bus.out_data, ref_word(d));
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_out_valid", bus.out_valid, 1'b1);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_first_word", got_q[$], ref_word(d));
    chk("bp_ready_after_hs", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_accept_gap", acc_q[$] - hs_q[$], 1);
    wait_out(lat);
    chk("bp_second_latency", lat, 11);
    recv("bp_second_word", ref_word(d2));

    // Reset in the middle of FEED.
    send(rand_word());
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    hs_base = hs_q.size();
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_out_data", bus.out_data, '0);
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    chk("midrst_sbox_in", bus.sbox_in, '0);
    step();
    chk("midrst_no_stale", bus.out_data, '0);
    send({W{1'b1}});
    wait_out(lat);
    chk("ones_latency", lat, 11);
    recv("ones_data", 60'hCF3CF3CF3CF3CF3);

    // Back-to-back with out_ready held high.
    for (int i = 0; i < 3; i++) w[i] = rand_word();
    n0 = got_q.size();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    k = 0;
    t = 0;
    while (k < 3 && t < 200) begin
      bus.in_data = w[k];
      if (bus.in_ready) k++;
      step();
      t++;
    end
    bus.in_valid = 1'b0;
    t = 0;
    while (got_q.size() < n0 + 3 && t < 200) begin step(); t++; end
    bus.out_ready = 1'b0;
    chk("b2b_timeout", 64'(got_q.size() >= n0 + 3), 64'd1);
    chk("b2b_gap_01", acc_q[$-1] - acc_q[$-2], 13);
    chk("b2b_gap_12", acc_q[$] - acc_q[$-1], 13);
    for (int i = 0; i < 3; i++)
      if (got_q.size() >= n0 + 3) chk($sformatf("b2b_word_%0d", i), got_q[n0+i], ref_word(w[i]));

    // Random words with random downstream stalls.
    for (int r = 0; r < 6; r++) begin
      d = rand_word();
      send(d);
      wait_out(lat);
      chk("rnd_latency", lat, 11);
      repeat ($urandom_range(0, 5)) begin
        chk("rnd_hold", bus.out_data, ref_word(d));
        step();
      end
      recv("rnd_data", ref_word(d));
    end

`ifdef ODO_SBOX_SEQ_PERF_EN
    chk("words_done", words_done, 64'(hs_q.size() - hs_base));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
